apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

Word-addressed APB completer holding a bank of 32-bit control/status registers. It sits directly downstream of the APB master FSM and consumes its PSEL/PENABLE/PADDR/PWDATA/PWRITE transfers. It returns PRDATA, PREADY and PSLVERR, with a fixed, parameterised number of wait states per transfer. Register 0 is a read-only identification word; all other registers are read/write.

## Interface
- NUM_REGS, 16: number of 32-bit registers, 2..256; index = PADDR[31:2].
- WAIT_CYCLES, 2: PREADY-low cycles inserted in every access phase, 0..15.
- ID_VALUE, 32'hA9B0_0001: constant returned by register 0.
- PCLK  in  1  clock; all state changes on rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- PSEL  in  1  completer select from master.
- PENABLE  in  1  access-phase indicator from master.
- PADDR  in  32  byte address.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; valid only while PREADY=1 on a read.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response; valid only while PREADY=1.

## Operation
- Reset (PRESETn=0, immediate, no clock needed):
  - state=IDLE; PREADY=0, PSLVERR=0, PRDATA=0.
  - Wait counter=0; registers 1..NUM_REGS-1 = 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Outputs low.
  - A setup phase (PSEL=1, PENABLE=0) at an edge latches PADDR, PWRITE and PWDATA into addr_q/wr_q/wdata_q, and computes err_q.
  - Counter loads WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - PREADY=0.
  - Counter decrements every edge. The edge where the counter goes 1→0 moves to RESP.
  - If PSEL=0 at an edge (master abort), return to IDLE with no write.
- RESP:
  - PREADY=1, PSLVERR=err_q.
  - Read with no error: PRDATA = register[addr_q[31:2]]. Register 0 reads ID_VALUE.
  - PRDATA=0 on writes and on errors.
  - At the next edge with PSEL=1 and PENABLE=1, a write with no error commits wdata_q to the register. State then goes to IDLE.
  - If PSEL=0 at that edge, go to IDLE with no write.
- err_q=1 when any of these holds:
  - PADDR[1:0]≠0;
  - PADDR[31:2] ≥ NUM_REGS, where any set upper bit counts as out of range;
  - write to index 0.
- Erroring writes never modify state.
- PRDATA, PREADY and PSLVERR are decoded from state and registered fields only. There is no combinational path from PADDR or PWDATA to the outputs.
- PENABLE=1 seen in IDLE (protocol violation): ignored, outputs stay low.

## Timing
- Cycle T: setup phase. T+1 .. T+WAIT_CYCLES: PREADY=0. T+WAIT_CYCLES+1: PREADY=1. Transfer length = WAIT_CYCLES+2 cycles.
- WAIT_CYCLES=0: zero-wait; PREADY=1 in the first access cycle T+1.
- Write data is visible to a read whose setup phase starts at or after the edge ending RESP.
- Back-to-back transfers: a setup phase in the cycle immediately after RESP is accepted normally (IDLE→WAIT/RESP on that edge).
- PSLVERR=0 and PRDATA=0 whenever PREADY=0.
- Reset asserted mid-transfer: outputs drop to reset values immediately and any pending write is discarded. The next transfer after PRESETn rises behaves normally.

## Test plan
- Reset, then read addr 0x00 with WAIT_CYCLES=2 → PREADY low for 2 access cycles then high, PRDATA=32'hA9B0_0001, PSLVERR=0, total 4 cycles.
- Write 0xDEADBEEF to 0x0C, then read 0x0C → write completes with PSLVERR=0; read returns 0xDEADBEEF; register 2 (0x08) still reads 0.
- Error cases:
  - Write 0x1234 to 0x00 → PSLVERR=1; later read of 0x00 still returns ID_VALUE.
  - Read 0x40 (NUM_REGS=16) → PSLVERR=1, PRDATA=0.
  - Read 0x06 (unaligned) → PSLVERR=1, PRDATA=0.
- WAIT_CYCLES=0 build: write 0x55 to 0x04 and read back → each transfer 2 cycles, PREADY=1 in first access cycle, PRDATA=0x55.
- PSEL dropped during WAIT of a write of 0xFFFF to 0x08 → FSM returns to IDLE, PREADY never asserts, 0x08 still reads 0.
- PRESETn pulsed low mid-WAIT after writing 0x77 to 0x04 earlier → PREADY/PSLVERR/PRDATA go 0 asynchronously; after release, 0x04 reads 0 and a fresh read of 0x00 completes normally.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB completer exposing a bank of 32-bit registers; register 0 is a read-only ID word.
// Every transfer takes WAIT_CYCLES wait states, then one response cycle.
module apb_slave_regfile #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int         IDX_W    = $clog2(NUM_REGS);
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  logic               wr_q, wr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [31:0]        regs_q [1:NUM_REGS-1];
  logic [31:0]        regs_d [1:NUM_REGS-1];

  logic               setup_phase;
  logic               in_range;
  logic               setup_err;
  logic               commit;
  logic [31:0]        rd_word;

  // Any set bit above the implemented index range makes the comparison fail.
  assign setup_phase = PSEL & ~PENABLE;
  assign in_range    = PADDR[31:2] < 30'(NUM_REGS);
  assign setup_err   = (PADDR[1:0] != 2'b00) | ~in_range |
                       (PWRITE & (PADDR[31:2] == 30'd0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (setup_phase) begin
          addr_d  = PADDR[IDX_W+1:2];
          wr_d    = PWRITE;
          wdata_d = PWDATA;
          err_d   = setup_err;
          cnt_d   = WAIT_CNT;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        commit  = PSEL & PENABLE & wr_q & ~err_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Register 0 has no storage; only indices 1..NUM_REGS-1 are flops.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = (commit && (addr_q == IDX_W'(i))) ? wdata_q : regs_q[i];
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          regs_q[gi] <= 32'd0;
        end else begin
          regs_q[gi] <= regs_d[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    rd_word = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (addr_q == IDX_W'(i)) begin
        rd_word = regs_q[i];
      end
    end
  end

  // Outputs depend only on state and latched fields.
  assign PREADY  = (state_q == ST_RESP);
  assign PSLVERR = PREADY & err_q;
  assign PRDATA  = (PREADY & ~wr_q & ~err_q) ? rd_word : 32'd0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: a WAIT_CYCLES=2 instance and a zero-wait instance.
module tb_apb_slave_regfile;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        slverr;
    int          cycles;
    int          leak;
  } res_t;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;

  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = 32'd0, pwdata = 32'd0;
  logic [31:0] prdata;
  logic        pready, pslverr;

  logic        z_psel = 1'b0, z_penable = 1'b0, z_pwrite = 1'b0;
  logic [31:0] z_paddr = 32'd0, z_pwdata = 32'd0;
  logic [31:0] z_prdata;
  logic        z_pready, z_pslverr;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  res_t obs_q[$];

  always #5 PCLK = ~PCLK;

  apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(2), .ID_VALUE(ID)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel), .PENABLE(penable),
    .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(0), .ID_VALUE(ID)) dut_zw (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(z_psel), .PENABLE(z_penable),
    .PADDR(z_paddr), .PWRITE(z_pwrite), .PWDATA(z_pwdata),
    .PRDATA(z_prdata), .PREADY(z_pready), .PSLVERR(z_pslverr)
  );

  task automatic set_bus(input bit z, input logic sel, input logic en,
                         input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    if (z) begin
      z_psel = sel; z_penable = en; z_paddr = addr; z_pwrite = wr; z_pwdata = wdata;
    end else begin
      psel = sel; penable = en; paddr = addr; pwrite = wr; pwdata = wdata;
    end
  endtask

  // Entered and left at posedge+1; consecutive calls are back-to-back transfers.
  task automatic xfer(input bit z, input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    res_t o;
    int   n;
    logic rdy, err;
    logic [31:0] rd;
    o.name = "obs"; o.rdata = 'x; o.slverr = 1'bx; o.cycles = -1; o.leak = 0;
    set_bus(z, 1'b1, 1'b0, addr, wr, wdata);
    @(posedge PCLK); #1;
    set_bus(z, 1'b1, 1'b1, addr, wr, wdata);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge PCLK);
      n++;
      rdy = z ? z_pready : pready;
      err = z ? z_pslverr : pslverr;
      rd  = z ? z_prdata : prdata;
      if (rdy === 1'b1) begin
        o.rdata = rd; o.slverr = err; o.cycles = n;
        break;
      end
      if (rd !== 32'd0 || err !== 1'b0) o.leak++;
      @(posedge PCLK); #1;
    end
    @(posedge PCLK); #1;
    set_bus(z, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    $display("xfer dut%0d addr=%h wr=%b wdata=%h -> rdata=%h slverr=%b cycles=%0d",
             z ? 0 : 2, addr, wr, wdata, o.rdata, o.slverr, o.cycles);
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    #13;
    checks++;
    if ({pready, pslverr, prdata} !== 34'd0 || {z_pready, z_pslverr, z_prdata} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%b/%h zw %b/%b/%h, want 0/0/0",
               pready, pslverr, prdata, z_pready, z_pslverr, z_prdata);
    end
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    checks++;
    if ({pready, pslverr, prdata} !== 34'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b/%b/%h, want 0/0/0", pready, pslverr, prdata);
    end
    @(posedge PCLK); #1;
  endtask

  task automatic test_id_read();
    res_t e, o;
    exp_q.push_back('{name:"id_read", rdata:ID, slverr:1'b0, cycles:4, leak:0});
    xfer(1'b0, 32'h00, 1'b0, 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: got no response, want one", e.name); continue; end
      o = obs_q.pop_front();
      if (o.rdata !== e.rdata || o.slverr !== e.slverr || o.cycles !== e.cycles || o.leak !== e.leak) begin
        errors++;
        $display("FAIL %s: got rdata=%h slverr=%b cycles=%0d leak=%0d, want rdata=%h slverr=%b cycles=%0d leak=0",
                 e.name, o.rdata, o.slverr, o.cycles, o.leak, e.rdata, e.slverr, e.cycles);
      end
    end
  endtask

  task automatic test_write_read();
    res_t e, o;
    exp_q.push_back('{name:"wr_0c", rdata:32'd0, slverr:1'b0, cycles:4, leak:0});
    xfer(1'b0, 32'h0C, 1'b1, 32'hDEAD_BEEF);
    exp_q.push_back('{name:"rd_0c", rdata:32'hDEAD_BEEF, slverr:1'b0, cycles:4, leak:0});
    xfer(1'b0, 32'h0C, 1'b0, 32'd0);
    exp_q.push_back('{name:"rd_08_zero", rdata:32'd0, slverr:1'b0, cycles:4, leak:0});
    xfer(1'b0, 32'h08, 1'b0, 32'd0);
    exp_q.push_back('{name:"wr_3c_last", rdata:32'd0, slverr:1'b0, cycles:4, leak:0});
    xfer(1'b0, 32'h3C, 1'b1, 32'hCAFE_0001);
    exp_q.push_back('{name:"rd_3c_last", rdata:32'hCAFE_0001, slverr:1'b0, cycles:4, leak:0});
    xfer(1'b0, 32'h3C, 1'b0, 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: got no response, want one", e.name); continue; end
      o = obs_q.pop_front();
      if (o.rdata !== e.rdata || o.slverr !== e.slverr || o.cycles !== e.cycles || o.leak !== e.leak) begin
        errors++;
        $display("FAIL %s: got rdata=%h slverr=%b cycles=%0d leak=%0d, want rdata=%h slverr=%b cycles=%0d leak=0",
                 e.name, o.rdata, o.slverr, o.cycles, o.leak, e.rdata, e.slverr, e.cycles);
      end
    end
  endtask

  task automatic test_errors();
    res_t e, o;
    exp_q.push_back('{name:"wr_id_err", rdata:32'd0, slverr:1'b1, cycles:4, leak:0});
    xfer(1'b0, 32'h00, 1'b1, 32'h0000_1234);
    exp_q.push_back('{name:"rd_id_kept", rdata:ID, slverr:1'b0, cycles:4, leak:0});
    xfer(1'b0, 32'h00, 1'b0, 32'd0);
    exp_q.push_back('{name:"rd_40_oor", rdata:32'd0, slverr:1'b1, cycles:4, leak:0});
    xfer(1'b0, 32'h40, 1'b0, 32'd0);
    exp_q.push_back('{name:"rd_06_unal", rdata:32'd0, slverr:1'b1, cycles:4, leak:0});
    xfer(1'b0, 32'h06, 1'b0, 32'd0);
    exp_q.push_back('{name:"rd_high_bit", rdata:32'd0, slverr:1'b1, cycles:4, leak:0});
    xfer(1'b0, 32'h8000_000C, 1'b0, 32'd0);
    exp_q.push_back('{name:"wr_0e_unal", rdata:32'd0, slverr:1'b1, cycles:4, leak:0});
    xfer(1'b0, 32'h0E, 1'b1, 32'h1111_2222);
    exp_q.push_back('{name:"wr_4c_alias", rdata:32'd0, slverr:1'b1, cycles:4, leak:0});
    xfer(1'b0, 32'h4C, 1'b1, 32'h3333_4444);
    exp_q.push_back('{name:"rd_0c_intact", rdata:32'hDEAD_BEEF, slverr:1'b0, cycles:4, leak:0});
    xfer(1'b0, 32'h0C, 1'b0, 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: got no response, want one", e.name); continue; end
      o = obs_q.pop_front();
      if (o.rdata !== e.rdata || o.slverr !== e.slverr || o.cycles !== e.cycles || o.leak !== e.leak) begin
        errors++;
        $display("FAIL %s: got rdata=%h slverr=%b cycles=%0d leak=%0d, want rdata=%h slverr=%b cycles=%0d leak=0",
                 e.name, o.rdata, o.slverr, o.cycles, o.leak, e.rdata, e.slverr, e.cycles);
      end
    end
  endtask

  task automatic test_zero_wait();
    res_t e, o;
    exp_q.push_back('{name:"zw_wr_04", rdata:32'd0, slverr:1'b0, cycles:2, leak:0});
    xfer(1'b1, 32'h04, 1'b1, 32'h55);
    exp_q.push_back('{name:"zw_rd_04", rdata:32'h55, slverr:1'b0, cycles:2, leak:0});
    xfer(1'b1, 32'h04, 1'b0, 32'd0);
    exp_q.push_back('{name:"zw_rd_id", rdata:ID, slverr:1'b0, cycles:2, leak:0});
    xfer(1'b1, 32'h00, 1'b0, 32'd0);
    exp_q.push_back('{name:"zw_rd_40", rdata:32'd0, slverr:1'b1, cycles:2, leak:0});
    xfer(1'b1, 32'h40, 1'b0, 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: got no response, want one", e.name); continue; end
      o = obs_q.pop_front();
      if (o.rdata !== e.rdata || o.slverr !== e.slverr || o.cycles !== e.cycles || o.leak !== e.leak) begin
        errors++;
        $display("FAIL %s: got rdata=%h slverr=%b cycles=%0d leak=%0d, want rdata=%h slverr=%b cycles=%0d leak=0",
                 e.name, o.rdata, o.slverr, o.cycles, o.leak, e.rdata, e.slverr, e.cycles);
      end
    end
  endtask

  task automatic test_abort();
    res_t e, o;
    int   ready_seen = 0;
    set_bus(1'b0, 1'b1, 1'b0, 32'h08, 1'b1, 32'h0000_FFFF);
    @(posedge PCLK); #1;
    set_bus(1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0000_FFFF);
    @(negedge PCLK); if (pready === 1'b1) ready_seen++;
    @(posedge PCLK); #1;
    set_bus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge PCLK); if (pready !== 1'b0) ready_seen++;
    end
    @(posedge PCLK); #1;
    checks++;
    if (ready_seen != 0) begin
      errors++;
      $display("FAIL abort_no_ready: got %0d ready cycles, want 0", ready_seen);
    end
    exp_q.push_back('{name:"abort_rd_08", rdata:32'd0, slverr:1'b0, cycles:4, leak:0});
    xfer(1'b0, 32'h08, 1'b0, 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: got no response, want one", e.name); continue; end
      o = obs_q.pop_front();
      if (o.rdata !== e.rdata || o.slverr !== e.slverr || o.cycles !== e.cycles || o.leak !== e.leak) begin
        errors++;
        $display("FAIL %s: got rdata=%h slverr=%b cycles=%0d leak=%0d, want rdata=%h slverr=%b cycles=%0d leak=0",
                 e.name, o.rdata, o.slverr, o.cycles, o.leak, e.rdata, e.slverr, e.cycles);
      end
    end
  endtask

  task automatic test_protocol_violation();
    int ready_seen = 0;
    set_bus(1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK); if (pready !== 1'b0 || prdata !== 32'd0) ready_seen++;
    end
    @(posedge PCLK); #1;
    set_bus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge PCLK); if (pready !== 1'b0) ready_seen++;
    @(posedge PCLK); #1;
    checks++;
    if (ready_seen != 0) begin
      errors++;
      $display("FAIL penable_in_idle: got %0d active cycles, want 0", ready_seen);
    end
  endtask

  task automatic test_reset_mid();
    res_t e, o;
    bit   hit = 0;
    exp_q.push_back('{name:"pre_wr_04", rdata:32'd0, slverr:1'b0, cycles:4, leak:0});
    xfer(1'b0, 32'h04, 1'b1, 32'h77);
    // Reset while a write to 0x08 sits in WAIT.
    set_bus(1'b0, 1'b1, 1'b0, 32'h08, 1'b1, 32'h0000_1111);
    @(posedge PCLK); #1;
    set_bus(1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0000_1111);
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    checks++;
    if ({pready, pslverr, prdata} !== 34'd0) begin
      errors++;
      $display("FAIL reset_mid_wait: got %b/%b/%h, want 0/0/0", pready, pslverr, prdata);
    end
    set_bus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
    // Reset while a read of ID is in RESP must clear outputs without a clock edge.
    set_bus(1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'd0);
    @(posedge PCLK); #1;
    set_bus(1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge PCLK);
      if (pready === 1'b1) begin hit = 1; break; end
    end
    #2 PRESETn = 1'b0;
    #1;
    checks++;
    if (!hit || pready !== 1'b0 || prdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_in_resp: got ready_seen=%0d pready=%b prdata=%h, want ready_seen=1 pready=0 prdata=0",
               hit, pready, prdata);
    end
    set_bus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
    exp_q.push_back('{name:"post_rd_04", rdata:32'd0, slverr:1'b0, cycles:4, leak:0});
    xfer(1'b0, 32'h04, 1'b0, 32'd0);
    exp_q.push_back('{name:"post_rd_08", rdata:32'd0, slverr:1'b0, cycles:4, leak:0});
    xfer(1'b0, 32'h08, 1'b0, 32'd0);
    exp_q.push_back('{name:"post_rd_id", rdata:ID, slverr:1'b0, cycles:4, leak:0});
    xfer(1'b0, 32'h00, 1'b0, 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: got no response, want one", e.name); continue; end
      o = obs_q.pop_front();
      if (o.rdata !== e.rdata || o.slverr !== e.slverr || o.cycles !== e.cycles || o.leak !== e.leak) begin
        errors++;
        $display("FAIL %s: got rdata=%h slverr=%b cycles=%0d leak=%0d, want rdata=%h slverr=%b cycles=%0d leak=0",
                 e.name, o.rdata, o.slverr, o.cycles, o.leak, e.rdata, e.slverr, e.cycles);
      end
    end
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_write_read();
    test_errors();
    test_zero_wait();
    test_abort();
    test_protocol_violation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, want $finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
